// File: rtl/cla_seq_addsub.sv
// Sequential add/subtract unit: one SLICE-bit carry-lookahead slice per clock,
// valid/ready handshakes on both sides, and a selectively updated Z/N/V/C register.
module cla_seq_addsub #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic [3:0]       cc
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Lookahead carries c[0..SLICE]: each carry is the OR of every generate
  // term propagated through the higher bits, plus cin through all propagates.
  function automatic logic [SLICE:0] cla_carries(input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y,
                                                 input logic             cin);
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] p;
    logic [SLICE:0]   c;
    logic             term;
    logic             part;
    g    = x & y;
    p    = x ^ y;
    c    = {(SLICE+1){1'b0}};
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      for (int j = 0; j <= i; j++) begin
        part = g[j];
        for (int k = j + 1; k <= i; k++) part = part & p[k];
        term = term | part;
      end
      c[i+1] = term;
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, setcc_q, setcc_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [3:0]       cc_q, cc_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [SLICE-1:0] a_sl_s, b_sl_s, sl_sum_s;
  logic [SLICE:0]   car_s;
  logic [WIDTH-1:0] res_s;
  logic [3:0]       flags_s;
  logic             last_s;

  // Current slice evaluation and the flags of the result as it would look after this slice.
  always_comb begin
    a_sl_s   = a_q[int'(idx_q)*SLICE +: SLICE];
    b_sl_s   = b_q[int'(idx_q)*SLICE +: SLICE];
    car_s    = cla_carries(a_sl_s, b_sl_s, carry_q);
    sl_sum_s = a_sl_s ^ b_sl_s ^ car_s[SLICE-1:0];
    last_s   = (idx_q == IDXW'(NSLICE - 1));
    res_s    = sum_q;
    res_s[int'(idx_q)*SLICE +: SLICE] = sl_sum_s;
    // On the last slice, car_s[SLICE-1] is the carry into the MSB.
    flags_s  = {(res_s == {WIDTH{1'b0}}), res_s[WIDTH-1],
                car_s[SLICE] ^ car_s[SLICE-1], car_s[SLICE]};
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    setcc_d = setcc_q;
    idx_d   = idx_q;
    cc_d    = cc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          setcc_d = set_cc;
          idx_d   = {IDXW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d   = res_s;
        carry_d = car_s[SLICE];
        if (last_s) begin
          state_d = S_DONE;
          if (setcc_q) cc_d = flags_s;
          else         cc_d = cc_q;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      setcc_q     <= 1'b0;
      idx_q       <= {IDXW{1'b0}};
      cc_q        <= 4'b0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      setcc_q     <= setcc_d;
      idx_q       <= idx_d;
      cc_q        <= cc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_cla_seq_addsub.sv
// Directed bench for cla_seq_addsub: an 8-bit and a 16-bit instance with hand-computed vectors.
module tb_cla_seq_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, iv8, ir8, sub8, sc8, ov8, or8;
  logic [7:0] a8, b8, s8;
  logic [3:0] cc8;

  logic        rst16, iv16, ir16, sub16, sc16, ov16, or16;
  logic [15:0] a16, b16, s16;
  logic [3:0]  cc16;

  int checks = 0;
  int failures = 0;

  cla_seq_addsub #(.WIDTH(8), .SLICE(4)) u_dut8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sub(sub8), .set_cc(sc8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cc(cc8)
  );

  cla_seq_addsub #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sub(sub16), .set_cc(sc16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cc(cc16)
  );

  // Present one operand to the 8-bit unit and count edges until out_valid.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic sc, output int lat);
    a8 = a; b8 = b; sub8 = s; sc8 = sc; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A; sub8 = ~s; sc8 = ~sc;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic sc, output int lat);
    a16 = a; b16 = b; sub16 = s; sc16 = sc; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'hA5A5; b16 = 16'h5A5A; sub16 = ~s; sc16 = ~sc;
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take8();
    or8 = 1'b1; @(posedge clk); #1; or8 = 1'b0;
  endtask

  task automatic take16();
    or16 = 1'b1; @(posedge clk); #1; or16 = 1'b0;
  endtask

  task automatic test_reset();
    rst8 = 1'b1; rst16 = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = 8'h00; b8 = 8'h00; sub8 = 1'b0; sc8 = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; sub16 = 1'b0; sc16 = 1'b0;
    #1;
    checks++;
    if ({ir8, ov8, s8, cc8} !== {1'b1, 1'b0, 8'h00, 4'h0}) begin
      failures++;
      $display("FAIL reset8: ir/ov/sum/cc=%b/%b/%h/%b want 1/0/00/0000", ir8, ov8, s8, cc8);
    end
    checks++;
    if ({ir16, ov16, s16, cc16} !== {1'b1, 1'b0, 16'h0000, 4'h0}) begin
      failures++;
      $display("FAIL reset16: ir/ov/sum/cc=%b/%b/%h/%b want 1/0/0000/0000", ir16, ov16, s16, cc16);
    end
    @(posedge clk); @(posedge clk); #1;
    rst8 = 1'b0; rst16 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow8();
    int lat;
    issue8(8'h7F, 8'h01, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL lat8: got %0d want 2", lat); end
    checks++;
    if (s8 !== 8'h80 || cc8 !== 4'b0110) begin
      failures++; $display("FAIL add_ovf8: sum=%h cc=%b want 80 0110", s8, cc8);
    end
    take8();
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      failures++; $display("FAIL idle8: ir=%b ov=%b want 1 0", ir8, ov8);
    end
  endtask

  task automatic test_sub_zero8();
    int lat;
    issue8(8'h05, 8'h05, 1'b1, 1'b1, lat);
    checks++;
    if (s8 !== 8'h00 || cc8 !== 4'b1001) begin
      failures++; $display("FAIL sub_zero8: sum=%h cc=%b want 00 1001", s8, cc8);
    end
    take8();
  endtask

  task automatic test_no_setcc8();
    int lat;
    issue8(8'h03, 8'h05, 1'b1, 1'b1, lat);
    checks++;
    if (s8 !== 8'hFE || cc8 !== 4'b0100) begin
      failures++; $display("FAIL sub_neg8: sum=%h cc=%b want FE 0100", s8, cc8);
    end
    take8();
    issue8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    checks++;
    if (s8 !== 8'h00 || cc8 !== 4'b0100 || lat !== 2) begin
      failures++; $display("FAIL no_setcc8: sum=%h cc=%b lat=%0d want 00 0100 2", s8, cc8, lat);
    end
    take8();
    checks++;
    if (cc8 !== 4'b0100) begin
      failures++; $display("FAIL cc_hold_idle8: cc=%b want 0100", cc8);
    end
  endtask

  task automatic test_backpressure16();
    int lat;
    issue16(16'h8000, 16'h8000, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL lat16: got %0d want 4", lat); end
    checks++;
    if (s16 !== 16'h0000 || cc16 !== 4'b1011) begin
      failures++; $display("FAIL add_carry16: sum=%h cc=%b want 0000 1011", s16, cc16);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ov16, ir16, s16, cc16} !== {1'b1, 1'b0, 16'h0000, 4'b1011}) begin
        failures++;
        $display("FAIL hold16[%0d]: ov/ir/sum/cc=%b/%b/%h/%b want 1/0/0000/1011", i, ov16, ir16, s16, cc16);
      end
    end
    take16();
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
      failures++; $display("FAIL release16: ir=%b ov=%b want 1 0", ir16, ov16);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a16 = 16'h00FF; b16 = 16'h0001; sub16 = 1'b0; sc16 = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h1000; b16 = 16'h0001; sub16 = 1'b1; sc16 = 1'b0;
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (s16 !== 16'h0100 || cc16 !== 4'b1011 || lat !== 4) begin
      failures++; $display("FAIL b2b_first: sum=%h cc=%b lat=%0d want 0100 1011 4", s16, cc16, lat);
    end
    or16 = 1'b1; @(posedge clk); #1; or16 = 1'b0;
    checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0) begin
      failures++; $display("FAIL b2b_bubble: ir=%b ov=%b want 1 0", ir16, ov16);
    end
    @(posedge clk); #1;
    iv16 = 1'b0;
    checks++;
    if (ir16 !== 1'b0) begin
      failures++; $display("FAIL b2b_accept: ir=%b want 0", ir16);
    end
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++;
    if (s16 !== 16'h0FFF || cc16 !== 4'b1011 || lat !== 4) begin
      failures++; $display("FAIL b2b_second: sum=%h cc=%b lat=%0d want 0FFF 1011 4", s16, cc16, lat);
    end
    take16();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; sc16 = 1'b1; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst16 = 1'b1;
    #1;
    checks++;
    if ({ir16, ov16, s16, cc16} !== {1'b1, 1'b0, 16'h0000, 4'h0}) begin
      failures++;
      $display("FAIL abort16: ir/ov/sum/cc=%b/%b/%h/%b want 1/0/0000/0000", ir16, ov16, s16, cc16);
    end
    @(posedge clk); #1;
    rst16 = 1'b0;
    @(posedge clk); #1;
    issue16(16'h0001, 16'h0002, 1'b1, 1'b1, lat);
    checks++;
    if (s16 !== 16'hFFFF || cc16 !== 4'b0100 || lat !== 4) begin
      failures++; $display("FAIL after_abort16: sum=%h cc=%b lat=%0d want FFFF 0100 4", s16, cc16, lat);
    end
    take16();
    issue16(16'h1234, 16'h4321, 1'b0, 1'b1, lat);
    checks++;
    if (s16 !== 16'h5555 || cc16 !== 4'b0000) begin
      failures++; $display("FAIL add16: sum=%h cc=%b want 5555 0000", s16, cc16);
    end
    take16();
  endtask

  initial begin
    test_reset();
    test_add_overflow8();
    test_sub_zero8();
    test_no_setcc8();
    test_backpressure16();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
